// File: rtl/line_stepper.sv
// Bresenham line stepper: loads two endpoints on set_new and emits one pixel
// per draw_enable until the end pixel is reached.
module line_stepper (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       set_new,
    input  logic       draw_enable,
    input  logic [9:0] x0,
    input  logic [9:0] y0,
    input  logic [9:0] x1,
    input  logic [9:0] y1,
    output logic [9:0] x_out,
    output logic [9:0] y_out,
    output logic       done,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        FIN
    } state_t;

    state_t            state_q, state_d;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic [9:0]        x1_q, x1_d, y1_q, y1_d;
    logic [10:0]       dx_q, dx_d;
    logic [10:0]       dy_q, dy_d;
    logic              sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic signed [11:0] err_q, err_d;
    logic              done_q, done_d, busy_q, busy_d;

    logic [10:0]        adx, ady;
    logic signed [12:0] e2, dx_ext, dy_ext;
    logic signed [11:0] err_step;
    logic               step_x, step_y;
    logic [9:0]         x_step, y_step;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        err_d    = err_q;

        adx = (x1 >= x0) ? {1'b0, x1 - x0} : {1'b0, x0 - x1};
        ady = (y1 >= y0) ? {1'b0, y1 - y0} : {1'b0, y0 - y1};

        // dx is non-negative and dy non-positive, so extend each accordingly
        e2     = $signed({err_q, 1'b0});
        dx_ext = $signed({2'b00, dx_q});
        dy_ext = $signed({{2{dy_q[10]}}, dy_q});
        step_x = (e2 >= dy_ext);
        step_y = (e2 <= dx_ext);

        err_step = err_q;
        if (step_x) err_step = err_step + $signed({dy_q[10], dy_q});
        if (step_y) err_step = err_step + $signed({1'b0, dx_q});

        x_step = x_q;
        y_step = y_q;
        if (step_x) x_step = sx_neg_q ? (x_q - 10'd1) : (x_q + 10'd1);
        if (step_y) y_step = sy_neg_q ? (y_q - 10'd1) : (y_q + 10'd1);

        if (set_new) begin
            x_d      = x0;
            y_d      = y0;
            x1_d     = x1;
            y1_d     = y1;
            dx_d     = adx;
            dy_d     = 11'd0 - ady;
            sx_neg_d = (x1 < x0);
            sy_neg_d = (y1 < y0);
            err_d    = $signed({1'b0, adx}) - $signed({1'b0, ady});
            state_d  = ((x0 == x1) && (y0 == y1)) ? FIN : DRAW;
        end else if (draw_enable && (state_q == DRAW)) begin
            x_d   = x_step;
            y_d   = y_step;
            err_d = err_step;
            if ((x_step == x1_q) && (y_step == y1_q)) state_d = FIN;
        end

        done_d = (state_d == FIN);
        busy_d = (state_d == DRAW);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            err_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            err_q    <= err_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign x_out = x_q;
    assign y_out = y_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule

// File: doc/line_stepper.md
LINE_STEPPER -- requirements
Module: line_stepper

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and n_rst as elsewhere in the codebase.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 n_rst  input  1  asynchronous active-low reset.
REQ-004 set_new  input  1  load new endpoints and restart the line (pulse from the render controller).
REQ-005 draw_enable  input  1  advance one pixel along the loaded line.
REQ-006 x0, y0  input  10 each  start point, unsigned, sampled only on set_new.
REQ-007 x1, y1  input  10 each  end point, unsigned, sampled only on set_new.
REQ-008 x_out, y_out  output  10 each  current pixel, registered.
REQ-009 done  output  1  current pixel equals end point, registered.
REQ-010 busy  output  1  a line is loaded and not finished, registered.

Function
REQ-011 The FSM SHALL have three states: IDLE (no line), DRAW (stepping), FIN (end pixel reached).
REQ-012 When set_new=1 at a clock edge, in any state, the block SHALL:
  - load x_out=x0, y_out=y0 and latch x1, y1;
  - set dx=|x1-x0|, dy=-|y1-y0|, sx=+1 if x1>=x0 else -1, sy=+1 if y1>=y0 else -1, err=dx+dy.
REQ-013 After that set_new edge, the FSM SHALL enter FIN if (x0,y0)==(x1,y1), otherwise DRAW.
REQ-014 set_new SHALL take priority over draw_enable in the same cycle; that draw_enable is ignored, with no step taken.
REQ-015 On draw_enable=1, set_new=0, state DRAW, the block SHALL take one Bresenham step:
  - e2=2*err;
  - if e2>=dy then err+=dy, x_out+=sx;
  - if e2<=dx then err+=dx, y_out+=sy;
  - both updates use the pre-step err and may apply in the same cycle.
REQ-016 If the stepped pixel equals (x1,y1), the FSM SHALL enter FIN on that same edge.
REQ-017 draw_enable in IDLE or FIN SHALL leave all state and outputs unchanged; the block does not step past the endpoint.
REQ-018 done SHALL be 1 exactly while in FIN; busy SHALL be 1 exactly while in DRAW.
REQ-019 Latency SHALL be one cycle: x_out, y_out and done reflect a set_new or step on the clock edge that samples it.
REQ-020 Widths:
  - err SHALL be 12-bit signed; e2 SHALL be 13-bit signed;
  - dx SHALL be held as 11-bit non-negative and dy as 11-bit non-positive, both sign-extended for comparison;
  - no overflow is permitted for any 10-bit endpoint pair.
REQ-021 Coordinates SHALL never wrap: every step moves toward the endpoint, and the maximum step count is max(|x1-x0|,|y1-y0|).
REQ-022 x0..y1 changing while set_new=0 SHALL have no effect.

Reset
REQ-023 While n_rst=0, the block SHALL asynchronously force state=IDLE, x_out=0, y_out=0, done=0, busy=0, and err, dx, dy, latched endpoints=0.
REQ-024 Reset asserted mid-line SHALL abandon the line; after release, draw_enable has no effect until the next set_new.
REQ-025 The first edge after reset release SHALL behave per REQ-012..REQ-017.

Verification
REQ-026 Horizontal line: set_new with (0,0)->(3,0), then 3 draw_enable pulses -> pixels (0,0),(1,0),(2,0),(3,0); done=0 until the third step, then done=1, busy=0.
REQ-027 Steep line: set_new with (0,0)->(1,3), then 3 steps -> (0,1),(1,2),(1,3); err sequence -2,-1,-3,-2; done=1 after step 3; a 4th draw_enable leaves (1,3) unchanged.
REQ-028 Reverse diagonal: set_new with (5,5)->(2,2) -> (5,5); steps give (4,4),(3,3),(2,2); done=1 after step 3.
REQ-029 Single point: set_new with (7,9)->(7,9) -> next cycle x_out=7, y_out=9, done=1, busy=0.
REQ-030 Restart and simultaneous inputs: mid-line, set_new and draw_enable both high with (10,0)->(12,0) -> (10,0), done=0, busy=1, no step taken.
REQ-031 Reset mid-line: after 2 steps of (0,0)->(3,0), pulse n_rst low asynchronously -> immediate x_out=0, y_out=0, done=0, busy=0; a later draw_enable without set_new changes nothing.
